// File: rtl/ms_wb_cmd_pkg.sv
// ms_wb_cmd_pkg
// Shared constants and types for the byte-stream Wishbone command master.
//   CMD_WR / CMD_RD   : command opcodes accepted on the rx byte stream
//   RSP_OK / RSP_ERR  : status bytes returned on the tx byte stream
//   state_t           : controller states
package ms_wb_cmd_pkg;

  localparam logic [7:0] CMD_WR  = 8'h57;  // 'W'
  localparam logic [7:0] CMD_RD  = 8'h52;  // 'R'
  localparam logic [7:0] RSP_OK  = 8'h4B;  // 'K'
  localparam logic [7:0] RSP_ERR = 8'h45;  // 'E'

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    BUS,
    RESP,
    RDATA
  } state_t;

endpackage

// File: rtl/ms_wb_cmd_master_if.sv
// ms_wb_cmd_master_if
// Bundles the command byte streams and the Wishbone classic bus of the
// command master.
//   rx_data/rx_valid/rx_ready : command bytes into the master
//   tx_data/tx_valid/tx_ready : response bytes out of the master
//   adr_o/dat_o/dat_i/sel_o/cyc_o/stb_o/we_o/ack_i : Wishbone classic
// Modports:
//   master : the command master itself
//   slave  : everything around it (byte source/sink and bus target)
interface ms_wb_cmd_master_if;

  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;

  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  logic [31:0] adr_o;
  logic [31:0] dat_o;
  logic [31:0] dat_i;
  logic [3:0]  sel_o;
  logic        cyc_o;
  logic        stb_o;
  logic        we_o;
  logic        ack_i;

  modport master (
    input  rx_data, rx_valid, tx_ready, dat_i, ack_i,
    output rx_ready, tx_data, tx_valid,
    output adr_o, dat_o, sel_o, cyc_o, stb_o, we_o
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, dat_i, ack_i,
    input  rx_ready, tx_data, tx_valid,
    input  adr_o, dat_o, sel_o, cyc_o, stb_o, we_o
  );

endinterface

// File: rtl/ms_wb_cmd_master.sv
// ms_wb_cmd_master
// Wishbone classic initiator driven by a byte-stream command protocol.
//   'W' a0 a1 a2 a3 d0 d1 d2 d3 : single write, address/data LSB first
//   'R' a0 a1 a2 a3             : single read, address LSB first
// Response: 'K' (plus 4 read-data bytes LSB first for reads) on ack,
// 'E' alone when the slave does not ack within TIMEOUT bus cycles.
// Unknown bytes arriving while idle are swallowed.
// Parameters:
//   TIMEOUT : bus cycles to wait for ack (1 .. 2**TO_W-1)
//   TO_W    : width of the timeout counter
// Ports:
//   clk_i : clock
//   rst_i : synchronous active-high reset
//   bus   : byte streams + Wishbone bus (master modport)
module ms_wb_cmd_master
  import ms_wb_cmd_pkg::*;
#(
  parameter int TIMEOUT = 200,
  parameter int TO_W    = 8
) (
  input logic                 clk_i,
  input logic                 rst_i,
  ms_wb_cmd_master_if.master  bus
);

  state_t            r_state;
  logic [1:0]        r_cnt;
  logic [TO_W-1:0]   r_to;
  logic [31:0]       r_adr;
  logic [31:0]       r_dat;
  logic [31:0]       r_rdata;
  logic              r_we;
  logic              r_ok;
  logic              r_cyc;
  logic              r_rxReady;
  logic              r_txValid;
  logic [7:0]        r_txData;

  logic              w_rxFire;
  logic              w_txFire;
  logic              w_timeout;
  logic [1:0]        w_nextCnt;

  assign w_rxFire  = bus.rx_valid & r_rxReady;
  assign w_txFire  = r_txValid & bus.tx_ready;
  assign w_nextCnt = r_cnt + 2'd1;

  // The counter starts at 0 on the first bus cycle, so reaching TIMEOUT-1
  // without ack means cyc has been high for exactly TIMEOUT cycles.
  assign w_timeout = (r_to == TO_W'(TIMEOUT - 1)) && !bus.ack_i;

  // Whole controller lives in one registered block so every output is a
  // flop: rx_ready, tx_valid/tx_data and cyc/stb all change on the same
  // edge as the state that implies them.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= IDLE;
      r_cnt     <= 2'd0;
      r_to      <= '0;
      r_adr     <= 32'd0;
      r_dat     <= 32'd0;
      r_rdata   <= 32'd0;
      r_we      <= 1'b0;
      r_ok      <= 1'b0;
      r_cyc     <= 1'b0;
      r_rxReady <= 1'b1;
      r_txValid <= 1'b0;
      r_txData  <= 8'd0;
    end else begin
      case (r_state)
        IDLE: begin
          // Anything other than a known opcode is consumed and dropped.
          if (w_rxFire && (bus.rx_data == CMD_WR || bus.rx_data == CMD_RD)) begin
            r_we    <= (bus.rx_data == CMD_WR);
            r_cnt   <= 2'd0;
            r_state <= ADDR;
          end
        end

        ADDR: begin
          if (w_rxFire) begin
            // LSB-first bytes enter at the top and slide down, so after
            // four bytes the first one sits in bits [7:0].
            r_adr <= {bus.rx_data, r_adr[31:8]};
            r_cnt <= w_nextCnt;
            if (r_cnt == 2'd3) begin
              if (r_we) begin
                r_state <= DATA;
              end else begin
                r_state   <= BUS;
                r_cyc     <= 1'b1;
                r_rxReady <= 1'b0;
                r_to      <= '0;
              end
            end
          end
        end

        DATA: begin
          if (w_rxFire) begin
            r_dat <= {bus.rx_data, r_dat[31:8]};
            r_cnt <= w_nextCnt;
            if (r_cnt == 2'd3) begin
              r_state   <= BUS;
              r_cyc     <= 1'b1;
              r_rxReady <= 1'b0;
              r_to      <= '0;
            end
          end
        end

        BUS: begin
          // Ack is checked first so an ack on the last allowed cycle
          // still counts as success.
          if (bus.ack_i) begin
            r_cyc     <= 1'b0;
            r_ok      <= 1'b1;
            r_rdata   <= bus.dat_i;
            r_txData  <= RSP_OK;
            r_txValid <= 1'b1;
            r_state   <= RESP;
          end else if (w_timeout) begin
            r_cyc     <= 1'b0;
            r_ok      <= 1'b0;
            r_txData  <= RSP_ERR;
            r_txValid <= 1'b1;
            r_state   <= RESP;
          end else begin
            r_to <= r_to + 1'b1;
          end
        end

        RESP: begin
          if (w_txFire) begin
            if (r_ok && !r_we) begin
              r_state  <= RDATA;
              r_cnt    <= 2'd0;
              r_txData <= r_rdata[7:0];
            end else begin
              r_state   <= IDLE;
              r_txValid <= 1'b0;
              r_rxReady <= 1'b1;
            end
          end
        end

        RDATA: begin
          // tx_data always shows byte r_cnt; on each accept the next
          // byte is loaded so bytes can leave at one per cycle.
          if (w_txFire) begin
            r_cnt <= w_nextCnt;
            if (r_cnt == 2'd3) begin
              r_state   <= IDLE;
              r_txValid <= 1'b0;
              r_rxReady <= 1'b1;
            end else begin
              r_txData <= r_rdata[{w_nextCnt, 3'b000} +: 8];
            end
          end
        end

        default: begin
          r_state   <= IDLE;
          r_cyc     <= 1'b0;
          r_txValid <= 1'b0;
          r_rxReady <= 1'b1;
        end
      endcase
    end
  end

  assign bus.rx_ready = r_rxReady;
  assign bus.tx_valid = r_txValid;
  assign bus.tx_data  = r_txData;
  assign bus.adr_o    = r_adr;
  assign bus.dat_o    = r_dat;
  assign bus.we_o     = r_we;
  assign bus.cyc_o    = r_cyc;
  assign bus.stb_o    = r_cyc;
  assign bus.sel_o    = 4'hF;

endmodule

// File: tb/tb_ms_wb_cmd_master.sv
// tb_ms_wb_cmd_master
// Self-checking bench for ms_wb_cmd_master: a table of command
// transactions (fixed corner cases plus randomized ones) is driven through
// the byte streams while a simple Wishbone slave answers; expected bus
// activity and response bytes come from a transaction-level model.
module tb_ms_wb_cmd_master;
  import ms_wb_cmd_pkg::*;

  localparam int TB_TIMEOUT = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int checks = 0;
  int errors = 0;

  ms_wb_cmd_master_if bus ();

  ms_wb_cmd_master #(
    .TIMEOUT(TB_TIMEOUT),
    .TO_W   (8)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // One transaction: stimulus fields followed by expected results.
  typedef struct {
    bit          isWrite;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          ackWait;   // bus cycle index carrying ack, -1 = never
    int          stall;     // initial cycles of tx_ready low
    int          garbage;   // junk bytes sent before the command
    bit          randReady; // random gaps / random tx_ready
    int          expCyc;
    logic [39:0] expRsp;    // response byte i at [8*i +: 8]
    int          expLen;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkVec(bit isWrite, logic [31:0] addr, logic [31:0] wdata,
                                 logic [31:0] rdata, int ackWait, int stall, int garbage,
                                 bit randReady, int expCyc, logic [39:0] expRsp, int expLen);
    vec_t v;
    v.isWrite = isWrite; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
    v.ackWait = ackWait; v.stall = stall; v.garbage = garbage; v.randReady = randReady;
    v.expCyc = expCyc; v.expRsp = expRsp; v.expLen = expLen;
    return v;
  endfunction

  // Transaction-level model: the slave either acks inside the allowed
  // window (cycles 0..TIMEOUT-1) or the master gives up after TIMEOUT cycles.
  function automatic vec_t refModel(vec_t v);
    bit acked;
    acked = (v.ackWait >= 0) && (v.ackWait < TB_TIMEOUT);
    v.expCyc = acked ? v.ackWait + 1 : TB_TIMEOUT;
    if (!acked) begin
      v.expRsp = {32'd0, 8'h45};
      v.expLen = 1;
    end else if (v.isWrite) begin
      v.expRsp = {32'd0, 8'h4B};
      v.expLen = 1;
    end else begin
      v.expRsp = {v.rdata, 8'h4B};
      v.expLen = 5;
    end
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [71:0] actual,
                             input logic [71:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic sendByte(input logic [7:0] b, input int gap, input bit noisyAck);
    int n;
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      bus.rx_valid = 1'b0;
      if (noisyAck) bus.ack_i = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    if (noisyAck) bus.ack_i = 1'($urandom_range(0, 1));
    n = 0;
    while (!bus.rx_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) checkOutput("rx_ready wait", 0, 1);
    @(posedge clk);
  endtask

  task automatic sendCommand(input vec_t v);
    logic [7:0] q[$];
    logic [7:0] g;
    for (int i = 0; i < v.garbage; i++) begin
      if (i == 0) g = 8'h00;
      else if (i == 1) g = 8'hFF;
      else begin
        g = 8'($urandom_range(0, 255));
        if (g == 8'h57 || g == 8'h52) g = 8'h13;
      end
      q.push_back(g);
    end
    q.push_back(v.isWrite ? 8'h57 : 8'h52);
    for (int i = 0; i < 4; i++) q.push_back(v.addr[8*i +: 8]);
    if (v.isWrite) for (int i = 0; i < 4; i++) q.push_back(v.wdata[8*i +: 8]);
    foreach (q[i]) sendByte(q[i], v.randReady ? $urandom_range(0, 2) : 0, v.randReady);
  endtask

  task automatic applyStimulus(input vec_t v, input string tag);
    int cyc;
    int got;
    int n;
    bit ready;
    bit prevValid;
    bit prevReady;
    logic [7:0] prevData;

    sendCommand(v);

    // First bus cycle: the edge after the last command byte.
    @(negedge clk);
    bus.rx_valid = 1'b0;
    bus.ack_i    = 1'b0;
    checkOutput({tag, " cyc start"}, bus.cyc_o, 1);
    cyc = 0;
    while (bus.cyc_o === 1'b1 && cyc < 100) begin
      checkOutput({tag, " bus hold"},
                  {bus.stb_o, bus.we_o, bus.sel_o, bus.adr_o, v.isWrite ? bus.dat_o : 32'd0},
                  {1'b1, v.isWrite, 4'hF, v.addr, v.isWrite ? v.wdata : 32'd0});
      bus.ack_i = (cyc == v.ackWait);
      bus.dat_i = (cyc == v.ackWait) ? v.rdata : $urandom;
      @(negedge clk);
      cyc++;
    end
    bus.ack_i = 1'b0;
    bus.dat_i = $urandom;
    checkOutput({tag, " cyc length"}, cyc, v.expCyc);
    checkOutput({tag, " resp start"}, {bus.tx_valid, bus.rx_ready, bus.stb_o}, 3'b100);

    got = 0;
    n = 0;
    prevValid = 1'b0;
    prevReady = 1'b1;
    prevData = 8'd0;
    while (got < v.expLen && n < 300) begin
      if (prevValid && !prevReady)
        checkOutput({tag, " tx hold"}, {bus.tx_valid, bus.tx_data}, {1'b1, prevData});
      ready = (n < v.stall) ? 1'b0 : (v.randReady ? 1'($urandom_range(0, 1)) : 1'b1);
      bus.tx_ready = ready;
      if (bus.tx_valid && ready) begin
        checkOutput($sformatf("%s rsp byte %0d", tag, got), bus.tx_data, v.expRsp[8*got +: 8]);
        got++;
      end
      prevValid = bus.tx_valid;
      prevReady = ready;
      prevData  = bus.tx_data;
      @(negedge clk);
      n++;
    end
    bus.tx_ready = 1'b0;
    checkOutput({tag, " rsp count"}, got, v.expLen);
    checkOutput({tag, " back to idle"}, {bus.tx_valid, bus.rx_ready}, 2'b01);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t v;
    bit sawTx;

    bus.rx_data  = 8'd0;
    bus.rx_valid = 1'b0;
    bus.tx_ready = 1'b0;
    bus.dat_i    = 32'd0;
    bus.ack_i    = 1'b0;

    // Reset state.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset ctrl",
                {bus.cyc_o, bus.stb_o, bus.we_o, bus.rx_ready, bus.tx_valid, bus.tx_data, bus.sel_o},
                {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 4'hF});
    checkOutput("reset bus", {bus.adr_o, bus.dat_o}, 64'd0);
    rst = 1'b0;

    // Fixed corner-case table (TIMEOUT = 5).
    vecs.push_back(mkVec(1, 32'h3000_0010, 32'hDEAD_BEEF, 32'h0, 1, 0, 0, 0, 2, 40'h00_0000_004B, 1));
    vecs.push_back(mkVec(0, 32'h3000_0004, 32'h0, 32'h0000_1234, 0, 0, 0, 0, 1, 40'h00_0012_344B, 5));
    vecs.push_back(mkVec(0, 32'h3000_0004, 32'h0, 32'h0000_1234, -1, 0, 0, 0, 5, 40'h00_0000_0045, 1));
    vecs.push_back(mkVec(0, 32'h3000_0004, 32'h0, 32'h0000_1234, 2, 0, 2, 0, 3, 40'h00_0012_344B, 5));
    vecs.push_back(mkVec(0, 32'h4000_0008, 32'h0, 32'hCAFE_F00D, 1, 10, 0, 0, 2, 40'hCA_FEF0_0D4B, 5));
    vecs.push_back(mkVec(1, 32'h1234_5678, 32'h0BAD_F00D, 32'h0, 4, 0, 0, 0, 5, 40'h00_0000_004B, 1));
    vecs.push_back(mkVec(1, 32'h1234_5678, 32'h0BAD_F00D, 32'h0, 5, 0, 0, 0, 5, 40'h00_0000_0045, 1));
    vecs.push_back(mkVec(0, 32'hFFFF_FFFC, 32'h0, 32'h8765_4321, 4, 0, 0, 0, 5, 40'h87_6543_214B, 5));

    // Randomized transactions, expectations from the model.
    for (int i = 0; i < 24; i++) begin
      int r;
      r = $urandom_range(0, 8);
      v = mkVec(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
                (r == 8) ? -1 : r, $urandom_range(0, 3), $urandom_range(0, 3), 1,
                0, 40'd0, 0);
      vecs.push_back(refModel(v));
    end

    for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i], $sformatf("v%0d", i));

    // Reset in the middle of a bus cycle: the cycle is abandoned silently.
    v = mkVec(1, 32'h1000_0000, 32'h1122_3344, 32'h0, -1, 0, 0, 0, 0, 40'd0, 0);
    sendCommand(v);
    @(negedge clk);
    bus.rx_valid = 1'b0;
    checkOutput("midbus cyc", bus.cyc_o, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midbus reset",
                {bus.cyc_o, bus.stb_o, bus.tx_valid, bus.rx_ready, bus.we_o, bus.adr_o},
                {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0});
    rst = 1'b0;
    bus.tx_ready = 1'b1;
    sawTx = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (bus.tx_valid || bus.cyc_o) sawTx = 1'b1;
    end
    bus.tx_ready = 1'b0;
    checkOutput("midbus no response", sawTx, 0);
    applyStimulus(mkVec(1, 32'h2000_0040, 32'h5566_7788, 32'h0, 1, 0, 0, 0,
                        2, 40'h00_0000_004B, 1), "after reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ms_wb_cmd_master.md
# ms_wb_cmd_master

Wishbone initiator driven by a byte-stream command protocol. It decodes read and write commands arriving as bytes (normally from a UART receiver FIFO), runs single Wishbone classic cycles on the system bus, and returns a status byte plus read data as a byte stream (normally to a UART transmitter FIFO). It is the host/debug-side counterpart to the Wishbone-attached peripherals such as the UART register block.

## Interface
- `TIMEOUT`, default 200: cycles to wait for `ack_i` before aborting. Legal range 1 to 2^TO_W-1.
- `TO_W`, default 8: width of the timeout counter.
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset; one clock; reset is synchronous and active-high.
- `rx_data`  in  8  command byte in.
- `rx_valid`  in  1  `rx_data` valid.
- `rx_ready`  out  1  block accepts `rx_data` this cycle.
- `tx_data`  out  8  response byte out.
- `tx_valid`  out  1  `tx_data` valid.
- `tx_ready`  in  1  sink accepts `tx_data` this cycle.
- `adr_o`  out  32  Wishbone address.
- `dat_o`  out  32  Wishbone write data.
- `dat_i`  in  32  Wishbone read data.
- `sel_o`  out  4  byte select; constant 4'hF.
- `cyc_o`  out  1  Wishbone cycle.
- `stb_o`  out  1  Wishbone strobe.
- `we_o`  out  1  Wishbone write enable.
- `ack_i`  in  1  Wishbone acknowledge.

## Operation
- **Byte transfer:** a byte moves when valid&ready on either stream.
- **Write command:** 0x57 ('W'), then 4 address bytes LSB first, then 4 data bytes LSB first.
- **Read command:** 0x52 ('R'), then 4 address bytes LSB first.
- **Unknown command byte in IDLE:** consumed and dropped; state stays IDLE.
- **Responses:**
  - Write: 0x4B ('K') on ack, 0x45 ('E') on timeout.
  - Read: 'K' followed by 4 bytes of the `dat_i` captured at ack, LSB first; 'E' alone on timeout.
- **States:**
  - IDLE: `rx_ready`=1. Goes to ADDR on 'W' or 'R'; `we_o` latched from the command.
  - ADDR: `rx_ready`=1. Shifts 4 bytes into `adr_o`, then goes to DATA if write, BUS if read.
  - DATA: `rx_ready`=1. Shifts 4 bytes into `dat_o`, then goes to BUS.
  - BUS: `cyc_o`=`stb_o`=1, `rx_ready`=0. `ack_i` goes to RESP with status K. Timeout goes to RESP with status E.
  - RESP: `tx_valid`=1, `tx_data`=status. On handshake, goes to RDATA if read and K, else IDLE.
  - RDATA: sends 4 captured bytes, then goes to IDLE.
- **Counters:** a 2-bit byte counter is shared by ADDR, DATA and RDATA and wraps 3→0 on the state change.
- **Timeout counter:** cleared on entry to BUS and incremented each BUS cycle without ack. Timeout fires when the counter equals TIMEOUT-1 and `ack_i`=0.
- **Ack and timeout in the same cycle:** ack wins.
- **`ack_i` outside BUS:** ignored.
- **Stable outputs:** `adr_o`, `dat_o` and `we_o` hold stable throughout BUS.

## Timing
- **Reset:** state IDLE. `cyc_o`=`stb_o`=`we_o`=0, `rx_ready`=1, `tx_valid`=0, `tx_data`=0, `adr_o`=0, `dat_o`=0, `sel_o`=4'hF.
- **Reset mid-transaction:** `cyc_o` and `stb_o` drop at the reset edge. No response is emitted.
- **Bus start:** `cyc_o`/`stb_o` rise on the clock edge after the last command byte is accepted.
- **Bus end on ack:** if `ack_i` is sampled high at edge N, `cyc_o`/`stb_o` are low after edge N. `tx_valid` rises at edge N with 'K', and read data is captured at edge N.
  - Required against a registered-ack slave: the first bus cycle has ack low and the second has ack high, giving `cyc_o` high for exactly 2 cycles.
- **Bus end on timeout:** `cyc_o` is high for exactly TIMEOUT cycles, then 'E' is presented.
- **Response stream:** `tx_data`/`tx_valid` hold steady until `tx_ready`. Back-to-back bytes are possible at 1 byte/cycle.
- **Next command:** `rx_ready` returns high the cycle after the final response byte is accepted.

## Structure
- Package `ms_wb_cmd_pkg`:
  - command constants CMD_WR=8'h57, CMD_RD=8'h52;
  - response constants RSP_OK=8'h4B, RSP_ERR=8'h45;
  - state enum {IDLE, ADDR, DATA, BUS, RESP, RDATA}.
- Single module. No sub-module is needed: the byte counter, timeout counter and shift registers stay inline.

## Test plan
- Write: bytes 57 10 00 00 30 EF BE AD DE, slave acks after 1 wait -> `adr_o`=3000_0010, `dat_o`=DEADBEEF, `we_o`=1, `cyc_o` high 2 cycles; response 4B.
- Read: bytes 52 04 00 00 30, slave returns 0000_1234 with ack -> response 4B 34 12 00 00; `we_o`=0 during BUS.
- Timeout with TIMEOUT=5: no ack -> `cyc_o` high exactly 5 cycles, response 45 only, then IDLE accepts a new 'R'.
- Garbage: bytes 00 FF 52 04 00 00 30 -> first two bytes dropped, one read performed.
- Backpressure: `tx_ready` low for 10 cycles during a read response -> `tx_data` stable at 4B, no byte lost or duplicated, sequence intact.
- Reset mid-BUS: assert `rst_i` while `cyc_o`=1 -> `cyc_o`=0 after the edge, no response; a following write completes normally.
